ads_sample_decimator: RTL and testbench

- Sits directly downstream of the ADS127L01 serial receiver. Consumes its 24-bit two's-complement sample and one-cycle valid pulse.
- Block-averages every 2^DECIM_LOG2 samples into one output sample.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready output handshake, feeding the DAQ packetiser.
- Flags FIFO overflow with a sticky bit.

---
 rtl/ads_sample_decimator.sv | 88 ++++++++
 tb/tb_ads_sample_decimator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ads_sample_decimator.sv
// Block-averaging decimator for the ADS127L01 sample stream, with a FWFT
// output FIFO (valid/ready) and a sticky overflow flag for dropped results.
module ads_sample_decimator #(
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [23:0]                   in_data,
  input  logic                          in_valid,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int ACC_W = 24 + DECIM_LOG2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = AW + 1;
  localparam logic [DECIM_LOG2:0] LAST = (DECIM_LOG2+1)'((1 << DECIM_LOG2) - 1);

  logic signed [ACC_W-1:0] acc, sum, shifted;
  logic [DECIM_LOG2:0]     cnt;
  logic                    push_req;
  logic [31:0]             push_data;

  // Wide enough that 2^DECIM_LOG2 full-scale samples can never wrap.
  assign sum     = acc + ACC_W'($signed(in_data));
  assign shifted = sum >>> DECIM_LOG2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (!en) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_valid) begin
        if (cnt < LAST) begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end else begin
          acc       <= '0;
          cnt       <= '0;
          push_req  <= 1'b1;
          push_data <= 32'($signed(shifted[23:0]));
        end
      end
    end
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [FW-1:0] wptr, rptr;
  logic          empty, full, pop, push_ok, drop;

  assign fill      = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign full      = (fill == FW'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign out_data  = empty ? 32'd0 : mem[rptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ads_sample_decimator.sv
// Scoreboard bench for ads_sample_decimator: expected averages are queued as
// blocks are driven and compared whenever the FIFO hands a word over.
module tb_ads_sample_decimator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fill;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ads_sample_decimator #(.DECIM_LOG2(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_word", {31'd0, out_valid}, 32'd0);
      else chk("data", out_data, sb.pop_front());
    end
  end

  task automatic put(input int v);
    in_valid = 1'b1;
    in_data  = 24'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic block(input int a, input int b, input int c, input int d, input bit keep);
    longint s, q;
    s = longint'(a) + longint'(b) + longint'(c) + longint'(d);
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    if (keep) sb.push_back(32'(q));
    put(a); put(b); put(c); put(d);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || fill != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    chk({tag, "_drained"}, 32'(sb.size()) | 32'(fill), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    idle(2);

    // basic average and latency
    block(100, 200, 300, 400, 1'b1);
    @(negedge clk); chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); chk("lat_n3_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_fill", 32'(fill), 32'd0);

    // floor rounding of negatives
    block(-1, 0, 0, 0, 1'b1);
    block(-8388608, -8388608, -8388608, -8388608, 1'b1);
    block(-5, 3, -2, 1, 1'b1);
    wait_drain("neg");

    // back-pressure and overflow
    out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) block(k*40, k*40, k*40, k*40 + 3, k <= 16);
    idle(3);
    chk("bp_fill", 32'(fill), 32'd16);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    chk("bp_head", out_data, 32'd40);
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // push into a full FIFO with a simultaneous pop
    out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) block(k, k, k, k, 1'b1);
    idle(2);
    chk("full_fill", 32'(fill), 32'd16);
    block(-700, -700, -700, -700, 1'b1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    idle(2);
    chk("full_pop_fill", 32'(fill), 32'd16);
    chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    wait_drain("full_pop");

    // enable toggle discards a partial block
    put(1000); put(1000);
    en = 1'b0;
    in_valid = 1'b1; in_data = 24'd77;
    idle(5);
    in_valid = 1'b0; en = 1'b1;
    block(8, 8, 8, 8, 1'b1);
    wait_drain("en");

    // asynchronous reset mid-frame with queued words
    out_ready = 1'b0;
    block(900, 900, 900, 900, 1'b1);
    block(-60, -60, -60, -60, 1'b1);
    put(5000); put(5000); put(5000);
    idle(2);
    chk("pre_rst_fill", 32'(fill), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    block(4, 4, 4, 4, 1'b1);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
